// File: rtl/multi_stage_database_loader_pkg.sv
// rtl/multi_stage_database_loader_pkg.sv - shared FSM state type and bank sizing helpers
package multi_stage_database_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int calc_stage_words(input int num_cls, input int num_par, input int num_thr);
    return num_cls * num_par + num_thr;
  endfunction

  function automatic int calc_total_words(input int num_stg, input int num_cls, input int num_par,
                                          input int num_thr);
    return num_stg * calc_stage_words(num_cls, num_par, num_thr);
  endfunction

endpackage

// File: rtl/multi_stage_database_loader_stage_word_counter.sv
// rtl/multi_stage_database_loader_stage_word_counter.sv - ROM address counter with stage/word split
module stage_word_counter #(
  parameter int ADDR_WIDTH  = 10,
  parameter int STAGE_WORDS = 193,
  parameter int TOTAL_WORDS = 386,
  parameter int SEL_W       = 1,
  parameter int WORD_W      = 8
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  i_clear,
  input  logic                  i_en,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [SEL_W-1:0]      o_stage_idx,
  output logic [WORD_W-1:0]     o_word_idx,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SEL_W-1:0]      r_stage;
  logic [WORD_W-1:0]     r_word;

  // Word index wraps at the stage boundary, which stands in for addr / STAGE_WORDS and addr % STAGE_WORDS
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga || i_clear) begin
      r_addr  <= '0;
      r_stage <= '0;
      r_word  <= '0;
    end else if (i_en) begin
      r_addr <= r_addr + ADDR_WIDTH'(1);
      if (r_word == WORD_W'(STAGE_WORDS - 1)) begin
        r_word  <= '0;
        r_stage <= r_stage + SEL_W'(1);
      end else begin
        r_word <= r_word + WORD_W'(1);
      end
    end
  end

  assign o_addr      = r_addr;
  assign o_stage_idx = r_stage;
  assign o_word_idx  = r_word;
  assign o_last      = (r_addr == ADDR_WIDTH'(TOTAL_WORDS - 1));

endmodule

// File: rtl/multi_stage_database_loader.sv
// rtl/multi_stage_database_loader.sv - streams cascade parameters from ROM into per-stage register banks
module multi_stage_database_loader
  import multi_stage_database_loader_pkg::*;
#(
  parameter int ADDR_WIDTH               = 10,
  parameter int DATA_WIDTH               = 12,
  parameter int NUM_STAGES               = 2,
  parameter int NUM_CLASSIFIERS          = 10,
  parameter int NUM_PARAM_PER_CLASSIFIER = 19,
  parameter int NUM_STAGE_THRESHOLD      = 3,
  parameter int AUTO_LOAD                = 1
) (
  input  logic                  clk_fpga,
  input  logic                  reset_fpga,
  input  logic                  i_reload,
  output logic                  o_rom_ren,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_data,
  input  logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] i_stage_sel,
  output logic [calc_stage_words(NUM_CLASSIFIERS, NUM_PARAM_PER_CLASSIFIER,
                                 NUM_STAGE_THRESHOLD)*DATA_WIDTH-1:0] o_stage_data,
  output logic [NUM_STAGES-1:0] o_stage_ready,
  output logic                  o_busy,
  output logic                  o_ready
);

  localparam int STAGE_WORDS = calc_stage_words(NUM_CLASSIFIERS, NUM_PARAM_PER_CLASSIFIER,
                                                NUM_STAGE_THRESHOLD);
  localparam int TOTAL_WORDS = calc_total_words(NUM_STAGES, NUM_CLASSIFIERS,
                                                NUM_PARAM_PER_CLASSIFIER, NUM_STAGE_THRESHOLD);
  localparam int SEL_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int WORD_W = (STAGE_WORDS > 1) ? $clog2(STAGE_WORDS) : 1;

  generate
    if (TOTAL_WORDS > 2**ADDR_WIDTH) begin : g_size_check
      $error("multi_stage_database_loader: TOTAL_WORDS exceeds ROM address space");
    end
  endgenerate

  state_t                r_state, w_next;
  logic                  r_first;
  logic                  w_start, w_cnt_clear, w_cnt_en, w_ren, w_busy, w_clear_flags;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [SEL_W-1:0]      w_stage_idx;
  logic [WORD_W-1:0]     w_word_idx;
  logic                  w_last;
  logic                  r_wr_en, r_wr_set;
  logic [SEL_W-1:0]      r_wr_stage;
  logic [WORD_W-1:0]     r_wr_word;
  logic [DATA_WIDTH-1:0] r_bank [NUM_STAGES][STAGE_WORDS];
  logic [NUM_STAGES-1:0] r_stage_ready;

  stage_word_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STAGE_WORDS(STAGE_WORDS),
    .TOTAL_WORDS(TOTAL_WORDS),
    .SEL_W      (SEL_W),
    .WORD_W     (WORD_W)
  ) u_counter (
    .clk_fpga   (clk_fpga),
    .reset_fpga (reset_fpga),
    .i_clear    (w_cnt_clear),
    .i_en       (w_cnt_en),
    .o_addr     (w_addr),
    .o_stage_idx(w_stage_idx),
    .o_word_idx (w_word_idx),
    .o_last     (w_last)
  );

  // r_first marks the single cycle after reset release that may auto-start a load
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      r_state <= ST_IDLE;
      r_first <= 1'b1;
    end else begin
      r_state <= w_next;
      r_first <= 1'b0;
    end
  end

  assign w_start = i_reload || ((AUTO_LOAD != 0) && r_first);

  always_comb begin
    w_next        = r_state;
    w_cnt_clear   = 1'b0;
    w_cnt_en      = 1'b0;
    w_ren         = 1'b0;
    w_busy        = 1'b0;
    w_clear_flags = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_next        = ST_FETCH;
          w_cnt_clear   = 1'b1;
          w_clear_flags = 1'b1;
        end
      end
      ST_FETCH: begin
        w_ren  = 1'b1;
        w_busy = 1'b1;
        if (i_reload) begin
          w_cnt_clear   = 1'b1;
          w_clear_flags = 1'b1;
        end else if (w_last) begin
          w_next      = ST_DRAIN;
          w_cnt_clear = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      ST_DRAIN: begin
        w_busy = 1'b1;
        w_next = i_reload ? ST_FETCH : ST_DONE;
        if (i_reload) begin
          w_cnt_clear   = 1'b1;
          w_clear_flags = 1'b1;
        end
      end
      default: begin
        if (i_reload) begin
          w_next        = ST_FETCH;
          w_cnt_clear   = 1'b1;
          w_clear_flags = 1'b1;
        end
      end
    endcase
  end

  // Aborted loads still land their in-flight word, but must not re-raise a stage flag
  always_ff @(posedge clk_fpga) begin
    if (reset_fpga) begin
      r_wr_en       <= 1'b0;
      r_wr_set      <= 1'b0;
      r_wr_stage    <= '0;
      r_wr_word     <= '0;
      r_stage_ready <= '0;
      for (int s = 0; s < NUM_STAGES; s++)
        for (int w = 0; w < STAGE_WORDS; w++)
          r_bank[s][w] <= '0;
    end else begin
      r_wr_en    <= w_ren;
      r_wr_stage <= w_stage_idx;
      r_wr_word  <= w_word_idx;
      r_wr_set   <= w_ren && (w_word_idx == WORD_W'(STAGE_WORDS - 1)) && !w_clear_flags;
      if (r_wr_en)
        r_bank[r_wr_stage][r_wr_word] <= i_rom_data;
      if (w_clear_flags)
        r_stage_ready <= '0;
      else if (r_wr_set)
        r_stage_ready[r_wr_stage] <= 1'b1;
    end
  end

  always_comb begin
    o_stage_data = '0;
    if (int'(i_stage_sel) < NUM_STAGES)
      for (int w = 0; w < STAGE_WORDS; w++)
        o_stage_data[w*DATA_WIDTH +: DATA_WIDTH] = r_bank[i_stage_sel][w];
  end

  assign o_rom_ren     = w_ren;
  assign o_rom_addr    = w_ren ? w_addr : '0;
  assign o_busy        = w_busy;
  assign o_ready       = (r_state == ST_DONE);
  assign o_stage_ready = r_stage_ready;

endmodule
